// File: rtl/mdio_controller.sv
// mdio_controller: Clause 22 MDIO master, one 32-bit frame per start, MDC = clk/2
//   in : clk, reset (async active-low), MDIO_START, MDIO_IN, T_DATA[31:0]
//   out: counter[5:0], MDC, MDIO_OUT, MDIO_OE, RD_DATA[15:0], DATA_RDY
module mdio_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDIO_START,
  input  logic        MDIO_IN,
  input  logic [31:0] T_DATA,
  output logic [5:0]  counter,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state, state_n;
  logic [31:0] frame, frame_n;
  logic [5:0]  cnt_n, cnt_inc;
  logic [15:0] rd_n;
  logic        mdc_n, out_n, oe_n, rdy_n, rd;
  assign rd      = frame[29:28] == 2'b10;
  assign cnt_inc = counter + 6'd1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= IDLE;
      frame    <= '0;
      counter  <= '0;
      MDC      <= 1'b0;
      MDIO_OUT <= 1'b0;
      MDIO_OE  <= 1'b0;
      RD_DATA  <= '0;
      DATA_RDY <= 1'b0;
    end else begin
      state    <= state_n;
      frame    <= frame_n;
      counter  <= cnt_n;
      MDC      <= mdc_n;
      MDIO_OUT <= out_n;
      MDIO_OE  <= oe_n;
      RD_DATA  <= rd_n;
      DATA_RDY <= rdy_n;
    end
  always_comb begin
    state_n = state;
    frame_n = frame;
    cnt_n   = counter;
    mdc_n   = 1'b0;
    out_n   = 1'b0;
    oe_n    = 1'b0;
    rd_n    = RD_DATA;
    rdy_n   = DATA_RDY;
    if (state == IDLE) begin
      cnt_n = 6'd0;
      if (MDIO_START) begin
        state_n = BUSY;
        frame_n = T_DATA;
        out_n   = T_DATA[31];
        oe_n    = 1'b1;
        rdy_n   = 1'b0;
      end
    end else if (!MDC) begin
      // rising MDC: bit held steady, PHY samples; read data shifts in here
      mdc_n = 1'b1;
      out_n = MDIO_OUT;
      oe_n  = MDIO_OE;
      rd_n  = (rd && counter >= 6'd16) ? {RD_DATA[14:0], MDIO_IN} : RD_DATA;
    end else if (counter == 6'd31) begin
      state_n = IDLE;
      cnt_n   = 6'd32;
      rdy_n   = rd;
    end else begin
      // falling MDC: advance to next bit; reads release the line from bit 14
      cnt_n = cnt_inc;
      oe_n  = !rd || cnt_inc <= 6'd13;
      out_n = oe_n & frame[~cnt_inc[4:0]];
    end
  end
endmodule

// File: tb/tb_mdio_controller.sv
// tb_mdio_controller: scoreboard bench for mdio_controller
module tb_mdio_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MDIO_START = 1'b0;
  logic        MDIO_IN = 1'b0;
  logic [31:0] T_DATA = '0;
  logic [5:0]  counter;
  logic        MDC, MDIO_OUT, MDIO_OE, DATA_RDY;
  logic [15:0] RD_DATA;
  int          total = 0;
  int          bad = 0;
  int          rises = 0;
  logic        mdc_q = 1'b0;
  bit          mon_en = 1'b1;
  logic [15:0] phy_word = '0;
  logic [15:0] rd_exp = '0;
  logic [1:0]  exp_q[$];

  mdio_controller dut (
    .clk(clk), .reset(reset), .MDIO_START(MDIO_START), .MDIO_IN(MDIO_IN),
    .T_DATA(T_DATA), .counter(counter), .MDC(MDC), .MDIO_OUT(MDIO_OUT),
    .MDIO_OE(MDIO_OE), .RD_DATA(RD_DATA), .DATA_RDY(DATA_RDY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // bit monitor: compare {OE,OUT} at every MDC high phase against the queue
  always @(negedge clk) begin
    if (reset && mon_en && MDC && !mdc_q) begin
      rises++;
      if (exp_q.size() == 0) chk("extra_bit", exp_q.size(), 1);
      else chk("frame_bit", {MDIO_OE, MDIO_OUT}, exp_q.pop_front());
    end
    mdc_q = MDC;
  end

  // PHY model: drive read data MSB-first while the line is released, junk during TA
  always @(negedge clk) begin
    logic [4:0] idx;
    idx = 5'd31 - counter[4:0];
    MDIO_IN = (!MDIO_OE && counter >= 6'd16 && counter <= 6'd31) ? phy_word[idx] : 1'b1;
  end

  task automatic run_frame(input logic [31:0] d, input logic [15:0] phy, input bit hold, input bit disturb);
    bit rd;
    int n, r0;
    bit done_dist;
    rd = d[29:28] == 2'b10;
    done_dist = 0;
    T_DATA = d;
    MDIO_START = 1'b1;
    phy_word = phy;
    for (int i = 31; i >= 0; i--) begin
      logic oe;
      oe = !rd || (31 - i) <= 13;
      exp_q.push_back({oe, oe & d[i]});
    end
    r0 = rises;
    @(negedge clk);
    chk("start_cnt", counter, 0);
    chk("start_oe", MDIO_OE, 1);
    chk("start_out", MDIO_OUT, d[31]);
    chk("start_rdy", DATA_RDY, 0);
    chk("start_mdc", MDC, 0);
    if (!hold) MDIO_START = 1'b0;
    n = 0;
    do begin
      n++;
      @(negedge clk);
      if (disturb && !done_dist && counter == 6'd10) begin
        MDIO_START = 1'b1;
        T_DATA = ~d;
        done_dist = 1;
      end else begin
        MDIO_START = hold;
        T_DATA = d;
      end
    end while (counter != 6'd32 && n < 100);
    if (rd) rd_exp = phy;
    chk("busy_clk", n, 64);
    chk("mdc_pulses", rises - r0, 32);
    chk("q_empty", exp_q.size(), 0);
    chk("end_mdc", MDC, 0);
    chk("end_oe", MDIO_OE, 0);
    chk("end_out", MDIO_OUT, 0);
    chk("end_rdy", DATA_RDY, rd);
    chk("rd_data", RD_DATA, rd_exp);
    if (!hold) begin
      @(negedge clk);
      chk("idle_cnt", counter, 0);
      chk("idle_mdc", MDC, 0);
      chk("idle_oe", MDIO_OE, 0);
      chk("idle_rdy", DATA_RDY, rd);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_cnt", counter, 0);
    chk("rst_mdc", MDC, 0);
    chk("rst_oe", MDIO_OE, 0);
    chk("rst_rd", RD_DATA, 0);
    chk("rst_rdy", DATA_RDY, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle0_cnt", counter, 0);
    chk("idle0_mdc", MDC, 0);
    run_frame(32'h5082_ABCD, 16'h0000, 0, 0);
    run_frame(32'h6088_0000, 16'hBEEF, 0, 0);
    run_frame(32'h5082_1234, 16'h0000, 0, 0);
    run_frame(32'h50C6_5A5A, 16'h0000, 0, 1);
    run_frame(32'h6104_0000, 16'h1357, 0, 1);
    run_frame(32'h7000_FFFF, 16'h0000, 0, 0);
    run_frame(32'h5555_3C3C, 16'h0000, 1, 0);
    run_frame(32'h6AAA_0000, 16'hA5C3, 1, 0);
    run_frame(32'h5123_4567, 16'h0000, 0, 0);
    // asynchronous reset in the middle of a read frame
    mon_en = 0;
    T_DATA = 32'h6088_0000;
    MDIO_START = 1'b1;
    @(negedge clk);
    MDIO_START = 1'b0;
    for (int i = 0; i < 40 && counter != 6'd7; i++) @(negedge clk);
    chk("pre_rst_cnt", counter, 7);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_cnt", counter, 0);
    chk("mid_rst_mdc", MDC, 0);
    chk("mid_rst_oe", MDIO_OE, 0);
    chk("mid_rst_rd", RD_DATA, 0);
    chk("mid_rst_rdy", DATA_RDY, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_hold_mdc", MDC, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_mdc", MDC, 0);
      chk("post_rst_cnt", counter, 0);
      chk("post_rst_oe", MDIO_OE, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdio_controller.md
Name: mdio_controller

Overview:
- MDIO management-interface master: serialises one 32-bit IEEE 802.3 Clause 22 frame (no preamble) from a parallel word onto MDIO, generates MDC, and for read operations captures 16 data bits from the PHY.
- Sits between the station-management logic, which supplies T_DATA and MDIO_START, and the PHY MDIO/MDC pins.
- Total MDIO frame time is 64 clk cycles.

Parameters:
- none. Frame length is fixed at 32 bits; MDC is fixed at clk/2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- MDIO_START  input  1  level; high while idle launches a transaction.
- MDIO_IN  input  1  serial data from PHY, used during read.
- T_DATA  input  32  frame word: [31:30] ST (01), [29:28] OP (01 write, 10 read), [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] write data.
- counter  output  6  current bit index, 0..32.
- MDC  output  1  management clock, clk/2 while busy, 0 when idle.
- MDIO_OUT  output  1  serial frame bit, MSB first.
- MDIO_OE  output  1  1 = controller drives MDIO.
- RD_DATA  output  16  data captured in a read.
- DATA_RDY  output  1  read data valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - Return to IDLE.
  - MDC=0, MDIO_OUT=0, MDIO_OE=0, counter=0, RD_DATA=0, DATA_RDY=0.
  - Latched frame cleared.
  - Reset mid-frame aborts the frame immediately.
- States: IDLE, BUSY.
- IDLE:
  - MDC=0, MDIO_OE=0, MDIO_OUT=0, counter holds 0.
  - On a clk edge with MDIO_START=1: latch T_DATA, enter BUSY.
  - On that same edge: MDC=0, counter=0, MDIO_OUT=T_DATA[31], MDIO_OE=1, DATA_RDY cleared.
- BUSY:
  - MDC toggles every clk edge.
  - Falling MDC edge (MDC 1->0): counter increments; MDIO_OUT=frame[31-counter].
  - So each bit is stable for one low phase plus one high phase (2 clk cycles), and the PHY samples on MDC rising.
- Write (OP != 10; 00/11 treated as write):
  - MDIO_OE=1 for counter 0..31.
- Read (OP=10):
  - MDIO_OE=1 for counter 0..13, 0 for counter 14..31 (turnaround + data). MDIO_OUT=0 while OE=0.
  - On each clk edge where MDC goes 0->1 with counter in 16..31: RD_DATA <= {RD_DATA[14:0], MDIO_IN}. MSB is received first.
  - MDIO_IN during TA (counter 14,15) is ignored.
- Frame end:
  - After the high phase of bit 31, the next edge sets counter=32, MDC=0, MDIO_OE=0, MDIO_OUT=0, and returns to IDLE.
  - counter returns to 0 on the following edge.
  - On a read, DATA_RDY=1 on the same edge. It stays high until the next accepted MDIO_START or reset.
  - RD_DATA holds its value until the next read shifts new bits in.
- MDIO_START while BUSY is ignored. T_DATA changes while BUSY have no effect (latched copy is used).
- MDIO_START still high on return to IDLE starts a new frame on the next edge.

Test Plan:
1. Reset: reset=0 mid-frame at counter=7 -> immediately MDC=0, MDIO_OE=0, counter=0, RD_DATA=0, DATA_RDY=0; no further MDC toggles.
2. Write: T_DATA=32'h5_0_8_2_ABCD, i.e. 0101_0000_1000_0010_1010_1011_1100_1101 (OP=01, PHYAD=00001, REGAD=00000, TA=10, data=ABCD), MDIO_START one cycle:
   - MDIO_OUT sampled at each MDC rise reproduces T_DATA MSB-first.
   - MDIO_OE=1 for all 32 bits.
   - 32 MDC pulses, 64 clk busy.
   - DATA_RDY stays 0.
3. Read: OP=10, PHY drives 16'hBEEF on MDIO_IN during counter 16..31 -> MDIO_OE=1 only for bits 0..13; RD_DATA=16'hBEEF; DATA_RDY=1 at counter=32.
4. DATA_RDY clear: after step 3, assert MDIO_START for a write -> DATA_RDY=0 on the start edge; RD_DATA stays 16'hBEEF.
5. Busy protection: pulse MDIO_START and change T_DATA at counter=10 -> frame continues unchanged with the original bits.
6. Back-to-back: hold MDIO_START high for 200 clk -> consecutive frames, each 64 clk busy plus 1 idle edge; counter sequence 0..32,0,0...
